// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader, the fetch-side memory and the bench.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } ldr_state_t;

  localparam logic [31:0] IMEM_BASE  = 32'hBFC00000;
  localparam int          IMEM_BYTES = 4096;
  localparam int          IMEM_OFF_W = 12;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream loader: length, image, checksum -> instruction memory writes.
// Holds the core in reset until a complete image with a good checksum is in place.
//
// state | meaning
// IDLE  | waiting for start after reset
// LEN   | collecting the 4 big-endian length bytes
// DATA  | writing image bytes, one write per accepted byte
// CSUM  | waiting for the checksum byte
// DONE  | image good, core released
// ERR   | length or checksum failure, core held
module imem_loader
  import imem_pkg::*;
#(
  parameter int          MEM_BYTES = IMEM_BYTES,
  parameter int          OFF_W     = IMEM_OFF_W,
  parameter logic [31:0] BASE_ADDR = IMEM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [OFF_W-1:0] OFF_ONE = OFF_W'(1);
  localparam logic [OFF_W:0]   REM_ONE = (OFF_W + 1)'(1);

  ldr_state_t       state_q;
  logic [1:0]       len_cnt_q;
  logic [23:0]      len_q;
  logic [OFF_W-1:0] offset_q;
  logic [OFF_W:0]   remaining_q;
  logic [7:0]       csum_q;
  logic             rx_ready_q;
  logic             wr_en_q;
  logic [31:0]      wr_addr_q;
  logic [7:0]       wr_data_q;
  logic             cpu_hold_q;
  logic             done_q;
  logic             err_q;

  logic             accept;
  logic [31:0]      len_d;
  logic [7:0]       csum_d;
  logic             len_bad;

  assign accept  = rx_valid & rx_ready_q;
  assign len_d   = {len_q, rx_data};
  assign csum_d  = csum_q + rx_data;
  // Word-aligned, non-empty and fits; this also guarantees the offset never wraps.
  assign len_bad = (len_d == 32'd0) || (len_d[1:0] != 2'd0) || (len_d > 32'(MEM_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_cnt_q   <= '0;
      len_q       <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      csum_q      <= '0;
      rx_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= BASE_ADDR;
      wr_data_q   <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LEN;
            rx_ready_q <= 1'b1;
            len_cnt_q  <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            len_q     <= len_d[23:0];
            len_cnt_q <= len_cnt_q + 2'd1;
            if (len_cnt_q == 2'd3) begin
              if (len_bad) begin
                state_q    <= ERR;
                rx_ready_q <= 1'b0;
                err_q      <= 1'b1;
              end else begin
                state_q     <= DATA;
                offset_q    <= '0;
                remaining_q <= len_d[OFF_W:0];
                csum_q      <= '0;
              end
            end
          end
        end
        DATA: begin
          if (accept) begin
            wr_en_q     <= 1'b1;
            wr_addr_q   <= BASE_ADDR + 32'(offset_q);
            wr_data_q   <= rx_data;
            csum_q      <= csum_d;
            offset_q    <= offset_q + OFF_ONE;
            remaining_q <= remaining_q - REM_ONE;
            if (remaining_q == REM_ONE) state_q <= CSUM;
          end
        end
        CSUM: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            if (rx_data == csum_q) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (start) begin
            state_q    <= LEN;
            rx_ready_q <= 1'b1;
            len_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are sent, a monitor pops them.
module tb_imem_loader;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  logic [31:0] last_addr;
  logic [39:0] exp_q[$];
  logic [7:0]  mem_m [0:IMEM_BYTES-1];
  logic [7:0]  img   [0:IMEM_BYTES-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && wr_en === 1'b1) begin
      logic [39:0] e;
      n_writes++;
      last_addr = wr_addr;
      mem_m[wr_addr[IMEM_OFF_W-1:0]] = wr_data;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h with nothing expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[39:8]);
        check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout: rx_ready %b required 1", rx_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] l, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(l[8*i +: 8], gap);
  endtask

  task automatic send_data(input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++) begin
      exp_q.push_back({IMEM_BASE + 32'(i), img[i]});
      send_byte(img[i], gap);
    end
  endtask

  function automatic logic [7:0] img_sum(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + img[i];
    return s;
  endfunction

  task automatic check_status(input string pfx, input logic d, input logic e, input logic h);
    @(negedge clk);
    check({pfx, "_done"},     {31'd0, done},     {31'd0, d});
    check({pfx, "_err"},      {31'd0, err},      {31'd0, e});
    check({pfx, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
  endtask

  task automatic load_nominal(input int gap);
    pulse_start();
    send_len(32'd8, gap);
    send_data(0, 8, gap);
    send_byte(img_sum(8), gap);
  endtask

  task automatic set_nominal();
    logic [63:0] v = 64'h00500093_00100113;
    for (int i = 0; i < 8; i++) img[i] = v[63 - 8*i -: 8];
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({pfx, "_wr_en"},    {31'd0, wr_en},    32'd0);
    check({pfx, "_wr_addr"},  wr_addr,           IMEM_BASE);
    check({pfx, "_wr_data"},  {24'd0, wr_data},  32'd0);
    check({pfx, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({pfx, "_done"},     {31'd0, done},     32'd0);
    check({pfx, "_err"},      {31'd0, err},      32'd0);
  endtask

  initial begin
    int w0;
    logic [31:0] bad_len [3];
    bad_len = '{32'd6, 32'd0, 32'h00001004};
    for (int i = 0; i < IMEM_BYTES; i++) mem_m[i] = 8'h00;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Nominal image: two big-endian instructions, checksum 0x07.
    set_nominal();
    w0 = n_writes;
    load_nominal(0);
    check_status("nominal", 1'b1, 1'b0, 1'b0);
    check("nominal_writes", 32'(n_writes - w0), 32'd8);
    check("nominal_word0", {mem_m[0], mem_m[1], mem_m[2], mem_m[3]}, 32'h00500093);
    check("nominal_word1", {mem_m[4], mem_m[5], mem_m[6], mem_m[7]}, 32'h00100113);

    // Same image with idle cycles between bytes.
    w0 = n_writes;
    load_nominal(3);
    check_status("gaps", 1'b1, 1'b0, 1'b0);
    check("gaps_writes", 32'(n_writes - w0), 32'd8);

    // Bad checksum, then recovery.
    w0 = n_writes;
    pulse_start();
    send_len(32'd8, 0);
    send_data(0, 8, 0);
    send_byte(8'h00, 0);
    check_status("badcsum", 1'b0, 1'b1, 1'b1);
    check("badcsum_writes", 32'(n_writes - w0), 32'd8);
    pulse_start();
    check("reload_err_cleared", {31'd0, err}, 32'd0);
    check("reload_rx_ready", {31'd0, rx_ready}, 32'd1);
    send_len(32'd8, 0);
    send_data(0, 8, 0);
    send_byte(img_sum(8), 0);
    check_status("recover", 1'b1, 1'b0, 1'b0);

    // Illegal lengths: error with no writes.
    foreach (bad_len[k]) begin
      w0 = n_writes;
      pulse_start();
      send_len(bad_len[k], 0);
      check_status("badlen", 1'b0, 1'b1, 1'b1);
      check("badlen_rx_ready", {31'd0, rx_ready}, 32'd0);
      repeat (2) @(negedge clk);
      check("badlen_writes", 32'(n_writes - w0), 32'd0);
    end

    // Image filling the whole memory.
    for (int i = 0; i < IMEM_BYTES; i++) img[i] = 8'(i * 7 + 3);
    w0 = n_writes;
    pulse_start();
    send_len(32'h00001000, 0);
    send_data(0, IMEM_BYTES, 0);
    send_byte(img_sum(IMEM_BYTES), 0);
    check_status("full", 1'b1, 1'b0, 1'b0);
    check("full_writes", 32'(n_writes - w0), 32'd4096);
    check("full_last_addr", last_addr, 32'hBFC00FFF);

    // Reset after three data bytes.
    set_nominal();
    pulse_start();
    send_len(32'd8, 0);
    send_data(0, 3, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load_nominal(0);
    check_status("after_rst", 1'b1, 1'b0, 1'b0);

    // start during DATA is ignored.
    w0 = n_writes;
    pulse_start();
    send_len(32'd8, 0);
    send_data(0, 4, 0);
    pulse_start();
    check("ignstart_rx_ready", {31'd0, rx_ready}, 32'd1);
    send_data(4, 8, 0);
    send_byte(img_sum(8), 0);
    check_status("ignstart", 1'b1, 1'b0, 1'b0);
    check("ignstart_writes", 32'(n_writes - w0), 32'd8);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
